irda_fir_4ppm_encoder: RTL
==========================

// Module: irda_fir_4ppm_encoder
// PURPOSE
//  FIR (4 Mb/s) transmit-side 4PPM chip encoder: accepts bytes via valid/ready, splits each into
//  four dibits LSB first, emits one chip per fir_tx8_enable strobe (8 Mchip/s) on ppme_o.
//  Raw-symbol mode passes preamble/start/stop chip patterns from the TX frame controller.
//  Sits between TX framing logic and the FIR output mux; dibit/chip mapping is the exact inverse of RX 4PPM decode.
// PARAMETERS
//  IDLE_CHIP   1'b0   ppme_o level driven for every chip when no data is available (underrun/idle)
// PORTS
//  clk            in   1  system clock
//  wb_rst_i       in   1  asynchronous active-high reset
//  fir_tx8_enable in   1  one-clk chip strobe, 8 MHz rate
//  ppme_restart   in   1  synchronous flush: clears buffers, counters, outputs
//  tx_data        in   8  byte (encode mode) or two raw 4-chip symbols (raw mode)
//  tx_raw         in   1  qualifies tx_data as raw chips; sampled with tx_valid
//  tx_valid       in   1  producer has a byte
//  tx_ready       out  1  holding register empty; transfer when tx_valid&tx_ready at clk edge
//  ppme_o         out  1  encoded chip stream, registered
//  ppme_busy      out  1  symbol in flight or holding register full
//  ppme_underrun  out  1  one-clk pulse: symbol boundary reached with no data while previous symbol was data
// BEHAVIOUR
//  Reset (wb_rst_i) and ppme_restart give identical state: ppme_o=IDLE_CHIP, tx_ready=1, ppme_busy=0,
//   ppme_underrun=0, chip_cnt=0, holding/shift empty. Restart wins over a same-cycle strobe or transfer.
//  Storage: holding reg (8b data + raw flag + full) and shift reg (8b + raw flag + symbols-left 0..4).
//  tx_ready = ~hold_full. Transfer sets hold_full next clk; may occur on any clk, strobe or not.
//  chip_cnt (2b) advances by 1 on every fir_tx8_enable, wraps 3->0. chip_cnt==0 marks symbol boundary.
//  On strobe with chip_cnt==0 (symbol fetch), priority:
//   1 shift reg has symbols left: take next symbol, decrement count.
//   2 else hold_full: move holding->shift (hold_full clears same edge; transfer in same clk is
//     accepted only if tx_ready was 1), take its first symbol.
//   3 else idle symbol: chips all IDLE_CHIP; ppme_underrun pulses if previous symbol was data.
//  Encode mode: 4 symbols/byte, dibit k = tx_data[2k+1:2k], k=0 first. Mapping (first chip left):
//   00->1000, 01->0100, 10->0010, 11->0001.
//  Raw mode: 2 symbols/byte: tx_data[7:4] then tx_data[3:0], bit 3 of each nibble first; no checking.
//  Chips: ppme_o <= sym[3] at fetch strobe, then sym[2],sym[1],sym[0] on next 3 strobes (one clk
//   latency from strobe). ppme_o holds between strobes.
//  Latency: byte accepted while fully idle -> first chip on ppme_o one clk after next chip_cnt==0 strobe.
//  Throughput: one byte per 16 strobes (encode) / 8 strobes (raw); back-to-back bytes gap-free if
//   tx_valid is presented before the shift reg empties.
//  ppme_busy = hold_full | (shift symbols left>0) | (current symbol is data and chip_cnt!=0).
//  Mode changes per byte only; tx_raw ignored when no transfer occurs.
//  Async reset mid-symbol truncates it; no partial-symbol completion.
// STRUCTURE
//  Shared defines file (irda_defines.v): 4PPM chip codes PPM_SYM_00..PPM_SYM_11, PPM_CHIPS_PER_SYM=4,
//   PPM_SYMS_PER_BYTE=4, PPM_RAW_SYMS_PER_BYTE=2; same constants used by the RX decoder.
//  One sub-module: irda_fir_4ppm_sym_enc, combinational dibit -> 4-chip code (the 4-entry table).
//  Top holds byte buffer, shift/symbol counters, chip counter, output register.
// TESTING
//  Byte 8'hE4 encode, strobe every 2 clks -> ppme_o chips 1000 0100 0010 0001; tx_ready rises 1 clk after accept.
//  Bytes 8'h1B then 8'hFF back-to-back -> 0001 0010 0100 1000 | 0001 x4, no gap, no underrun.
//  Raw byte 8'h80 repeated 16x with tx_raw=1 -> chips 1000 0000 repeated, busy stays 1.
//  Stop tx_valid after one byte -> after last chip IDLE_CHIP, single ppme_underrun pulse at next
//   boundary, no further pulses while idle.
//  ppme_restart mid-byte (chip_cnt=2) with hold full -> next clk ppme_o=IDLE_CHIP, tx_ready=1,
//   busy=0; next byte restarts from chip 0.
//  Loopback through RX 4PPM decoder for 256 random bytes -> decoded bits equal sent bits, LSB first,
//   no bad chips.

Source files
------------

// File: rtl/irda_fir_4ppm_encoder_pkg.sv
// Shared FIR 4PPM constants and types. The RX 4PPM decoder uses the same chip codes,
// so the encode and decode mappings stay exact inverses.
package irda_fir_4ppm_encoder_pkg;

    // Chip codes, first transmitted chip in bit 3
    localparam logic [3:0] PPM_SYM_00 = 4'b1000;
    localparam logic [3:0] PPM_SYM_01 = 4'b0100;
    localparam logic [3:0] PPM_SYM_10 = 4'b0010;
    localparam logic [3:0] PPM_SYM_11 = 4'b0001;

    localparam logic [2:0] PPM_CHIPS_PER_SYM     = 3'd4;
    localparam logic [2:0] PPM_SYMS_PER_BYTE     = 3'd4;
    localparam logic [2:0] PPM_RAW_SYMS_PER_BYTE = 3'd2;

    typedef struct packed {
        logic [7:0] data;
        logic       raw;
    } ppm_byte_t;

    typedef enum logic [1:0] {
        FETCH_NONE,
        FETCH_SHIFT,
        FETCH_HOLD,
        FETCH_IDLE
    } fetch_e;

endpackage

// File: rtl/irda_fir_4ppm_sym_enc.sv
// Combinational 4PPM symbol encoder: one dibit to its 4-chip code.
module irda_fir_4ppm_sym_enc
    import irda_fir_4ppm_encoder_pkg::*;
(
    input  logic [1:0] dibit,
    output logic [3:0] chips
);

    always_comb begin
        chips = PPM_SYM_00;
        case (dibit)
            2'b00: chips = PPM_SYM_00;
            2'b01: chips = PPM_SYM_01;
            2'b10: chips = PPM_SYM_10;
            2'b11: chips = PPM_SYM_11;
            default: chips = PPM_SYM_00;
        endcase
    end

endmodule

// File: rtl/irda_fir_4ppm_encoder.sv
// FIR 4 Mb/s transmit 4PPM encoder: byte holding register, symbol shift register,
// chip counter and registered chip output. Raw mode passes 4-chip nibbles through unchanged.
module irda_fir_4ppm_encoder
    import irda_fir_4ppm_encoder_pkg::*;
#(
    parameter logic IDLE_CHIP = 1'b0
) (
    input  logic       clk,
    input  logic       wb_rst_i,
    input  logic       fir_tx8_enable,
    input  logic       ppme_restart,
    input  logic [7:0] tx_data,
    input  logic       tx_raw,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ppme_o,
    output logic       ppme_busy,
    output logic       ppme_underrun
);

    ppm_byte_t  hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    ppm_byte_t  shift_q, shift_d;
    logic [2:0] shift_left_q, shift_left_d;
    logic [1:0] chip_cnt_q, chip_cnt_d;
    logic [3:0] sym_q, sym_d;
    logic       sym_data_q, sym_data_d;
    logic       ppme_q, ppme_d;
    logic       underrun_q, underrun_d;

    fetch_e     fetch;
    ppm_byte_t  src;
    logic [3:0] enc_chips;
    logic [3:0] next_sym;

    always_comb begin
        fetch = FETCH_NONE;
        if (fir_tx8_enable && chip_cnt_q == 2'd0) begin
            if (shift_left_q != 3'd0) fetch = FETCH_SHIFT;
            else if (hold_full_q)     fetch = FETCH_HOLD;
            else                      fetch = FETCH_IDLE;
        end
    end

    assign src = (fetch == FETCH_HOLD) ? hold_q : shift_q;

    irda_fir_4ppm_sym_enc u_sym_enc (
        .dibit (src.data[1:0]),
        .chips (enc_chips)
    );

    assign next_sym = src.raw ? src.data[7:4] : enc_chips;

    always_comb begin
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        shift_left_d = shift_left_q;
        chip_cnt_d   = chip_cnt_q;
        sym_d        = sym_q;
        sym_data_d   = sym_data_q;
        ppme_d       = ppme_q;
        underrun_d   = 1'b0;

        // sym_q holds the chips still to be sent, next one in bit 3
        if (fir_tx8_enable) begin
            chip_cnt_d = chip_cnt_q + 2'd1;
            ppme_d     = sym_q[3];
            sym_d      = {sym_q[2:0], IDLE_CHIP};
        end

        case (fetch)
            FETCH_SHIFT, FETCH_HOLD: begin
                ppme_d       = next_sym[3];
                sym_d        = {next_sym[2:0], IDLE_CHIP};
                sym_data_d   = 1'b1;
                shift_d.raw  = src.raw;
                shift_d.data = src.raw ? {src.data[3:0], 4'h0} : {2'b00, src.data[7:2]};
                if (fetch == FETCH_SHIFT) begin
                    shift_left_d = shift_left_q - 3'd1;
                end else begin
                    shift_left_d = (src.raw ? PPM_RAW_SYMS_PER_BYTE : PPM_SYMS_PER_BYTE) - 3'd1;
                    hold_full_d  = 1'b0;
                end
            end
            FETCH_IDLE: begin
                ppme_d     = IDLE_CHIP;
                sym_d      = {4{IDLE_CHIP}};
                sym_data_d = 1'b0;
                underrun_d = sym_data_q;
            end
            default: ;
        endcase

        // A hold->shift move only happens when hold was full, so it never collides with a transfer
        if (tx_valid && !hold_full_q) begin
            hold_d.data = tx_data;
            hold_d.raw  = tx_raw;
            hold_full_d = 1'b1;
        end

        if (ppme_restart) begin
            hold_d       = '0;
            hold_full_d  = 1'b0;
            shift_d      = '0;
            shift_left_d = 3'd0;
            chip_cnt_d   = 2'd0;
            sym_d        = {4{IDLE_CHIP}};
            sym_data_d   = 1'b0;
            ppme_d       = IDLE_CHIP;
            underrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            shift_left_q <= 3'd0;
            chip_cnt_q   <= 2'd0;
            sym_q        <= {4{IDLE_CHIP}};
            sym_data_q   <= 1'b0;
            ppme_q       <= IDLE_CHIP;
            underrun_q   <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            shift_left_q <= shift_left_d;
            chip_cnt_q   <= chip_cnt_d;
            sym_q        <= sym_d;
            sym_data_q   <= sym_data_d;
            ppme_q       <= ppme_d;
            underrun_q   <= underrun_d;
        end
    end

    assign tx_ready      = ~hold_full_q;
    assign ppme_o        = ppme_q;
    assign ppme_underrun = underrun_q;
    assign ppme_busy     = hold_full_q | (shift_left_q != 3'd0) | (sym_data_q & (chip_cnt_q != 2'd0));

endmodule
